// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer
// Commutation timing source for one motor. It produces the six-step
// commutation index, the per-segment timebase counter with its
// last/second-to-last flags, and the PWM split index within a step. These
// feed the three phase line generators.
//
// Ports
//   clk                   system clock (10 MHz)
//   nRst                  asynchronous active-low reset
//   m3r_enable            run request (level)
//   m3r_dir               1 = forward (step+1), 0 = reverse (step-1)
//   m3r_stepCNT_speedSET  segment length in clocks (values below SPEED_MIN are raised to it)
//   m3r_stepSplitMax      segments per step minus 1
//   m3cnt                 segment timebase counter
//   m3cntLast1            high on the last clock of a segment
//   m3cntLast2            high on the second-to-last clock of a segment
//   m3LpwmSplitStep       split index within the current step
//   lgStep                commutation index, or STEP_IDLE when not running
//   stepTick              one-clock pulse when lgStep moves between running steps
//   running               high in RUN and STOPPING
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | outputs idle, waiting for m3r_enable
// START    | first clock of step 0, segment length and split count latched
// RUN      | counting segments, advancing split and step at boundaries
// STOPPING | one clock of idle outputs with running still high
module motoro3_step_sequencer #(
  parameter int STEP_MAX  = 5,
  parameter int STEP_IDLE = 15,
  parameter int SPEED_MIN = 2
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3r_enable,
  input  logic        m3r_dir,
  input  logic [24:0] m3r_stepCNT_speedSET,
  input  logic [1:0]  m3r_stepSplitMax,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic        m3cntLast2,
  output logic [1:0]  m3LpwmSplitStep,
  output logic [3:0]  lgStep,
  output logic        stepTick,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOPPING
  } state_t;

  localparam logic [24:0] SPEED_MIN_W = 25'(SPEED_MIN);
  localparam logic [3:0]  STEP_MAX_W  = 4'(STEP_MAX);
  localparam logic [3:0]  STEP_IDLE_W = 4'(STEP_IDLE);

  state_t      state_q, state_d;
  logic [24:0] len_q, len_d;
  logic [1:0]  smax_q, smax_d;
  logic [24:0] cnt_d;
  logic [1:0]  split_d;
  logic [3:0]  step_d;
  logic        tick_d;
  logic        last1_d, last2_d, running_d;
  logic [24:0] len_sat;
  logic        boundary;
  logic        counting_d;

  assign len_sat  = (m3r_stepCNT_speedSET < SPEED_MIN_W) ? SPEED_MIN_W : m3r_stepCNT_speedSET;
  assign boundary = (m3cnt == len_q - 25'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    smax_d  = smax_q;
    cnt_d   = m3cnt;
    split_d = m3LpwmSplitStep;
    step_d  = lgStep;
    tick_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d   = 25'd0;
        split_d = 2'd0;
        step_d  = STEP_IDLE_W;
        if (m3r_enable) begin
          state_d = S_START;
          len_d   = len_sat;
          smax_d  = m3r_stepSplitMax;
          step_d  = 4'd0;
        end
      end

      S_START, S_RUN: begin
        // START shows cnt=0 of the first segment; len >= 2 so it is never a boundary.
        state_d = S_RUN;
        if (boundary) begin
          cnt_d  = 25'd0;
          len_d  = len_sat;
          smax_d = m3r_stepSplitMax;
          // A stop request is cancelled by re-enabling, so the enable level
          // seen at the boundary decides whether the run continues.
          if (!m3r_enable) begin
            state_d = S_STOPPING;
            split_d = 2'd0;
            step_d  = STEP_IDLE_W;
          end else if (m3LpwmSplitStep < smax_q) begin
            split_d = m3LpwmSplitStep + 2'd1;
          end else begin
            split_d = 2'd0;
            tick_d  = 1'b1;
            if (m3r_dir)
              step_d = (lgStep == STEP_MAX_W) ? 4'd0 : lgStep + 4'd1;
            else
              step_d = (lgStep == 4'd0) ? STEP_MAX_W : lgStep - 4'd1;
          end
        end else begin
          cnt_d = m3cnt + 25'd1;
        end
      end

      S_STOPPING: begin
        state_d = S_IDLE;
        cnt_d   = 25'd0;
        split_d = 2'd0;
        step_d  = STEP_IDLE_W;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 25'd0;
        split_d = 2'd0;
        step_d  = STEP_IDLE_W;
      end
    endcase

    // Flags are computed against the next count and length so they line up
    // with the m3cnt value they describe.
    counting_d = (state_d == S_START) || (state_d == S_RUN);
    last1_d    = counting_d && (cnt_d == len_d - 25'd1);
    last2_d    = counting_d && (cnt_d == len_d - 25'd2);
    running_d  = (state_d == S_RUN) || (state_d == S_STOPPING);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      len_q           <= SPEED_MIN_W;
      smax_q          <= 2'd0;
      m3cnt           <= 25'd0;
      m3cntLast1      <= 1'b0;
      m3cntLast2      <= 1'b0;
      m3LpwmSplitStep <= 2'd0;
      lgStep          <= STEP_IDLE_W;
      stepTick        <= 1'b0;
      running         <= 1'b0;
    end else begin
      len_q           <= len_d;
      smax_q          <= smax_d;
      m3cnt           <= cnt_d;
      m3cntLast1      <= last1_d;
      m3cntLast2      <= last2_d;
      m3LpwmSplitStep <= split_d;
      lgStep          <= step_d;
      stepTick        <= tick_d;
      running         <= running_d;
    end
  end

endmodule
